// File: rtl/conv_pkg.sv
// Shared types and helpers for the 1-D convolution layer: FSM states,
// accumulator sizing, saturation and the kernel/bias ROM contents.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMPUTE,
        DONE
    } conv_state_e;

    // Full-precision products plus enough headroom for every tap and the bias.
    function automatic int acc_width(input int ws, input int kh, input int kw);
        return 2 * ws + $clog2(kh * kw) + 1;
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int ws);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (ws - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (ws - 1));
        if (v > max_v) begin
            return max_v;
        end else if (v < min_v) begin
            return min_v;
        end
        return v;
    endfunction

    // Kernel ROM image, row-major w[r][c] at r*KW+c. Mirrors the contents of
    // conv_weights_<layer>_<conv>.mem so the ROM needs no file at elaboration.
    function automatic logic [63:0] kernel_weight(input int layer, input int conv,
                                                  input int idx);
        logic [63:0] w;
        w = 64'h0;
        if (layer == 1 && conv == 0) begin
            case (idx)
                0: w = 64'h01;
                1: w = 64'h06;
                2: w = 64'h01;
                3: w = 64'h05;
                4: w = 64'h02;
                5: w = 64'h03;
                default: w = 64'h0;
            endcase
        end
        return w;
    endfunction

    // Bias image, matching conv_bias_<layer>_<conv>.mem.
    function automatic logic [63:0] kernel_bias(input int layer, input int conv);
        logic [63:0] b;
        b = 64'h0;
        if (layer == 1 && conv == 0) begin
            b = 64'h0f;
        end
        return b;
    endfunction

endpackage

// File: rtl/conv_mac_node.sv
// One output node: bias-initialised accumulator, shift/saturate output stage.
// Optional ReLU on the saturated result when CONV_RELU_EN is defined.
module conv_mac_node
    import conv_pkg::*;
#(
    parameter int WORD_SIZE     = 8,
    parameter int INT_BITS      = 8,
    parameter int KERNEL_HEIGHT = 3,
    parameter int KERNEL_WIDTH  = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 clear_i,
    input  logic                 acc_en_i,
    input  logic                 last_i,
    input  logic [WORD_SIZE-1:0] x_i,
    input  logic [WORD_SIZE-1:0] w_i,
    input  logic [WORD_SIZE-1:0] bias_i,
    output logic [WORD_SIZE-1:0] data_o
);

    localparam int FRAC   = WORD_SIZE - INT_BITS;
    localparam int ACC_W  = acc_width(WORD_SIZE, KERNEL_HEIGHT, KERNEL_WIDTH);
    localparam int PROD_W = 2 * WORD_SIZE;

    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [WORD_SIZE-1:0]     data_q, data_d;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [63:0]       shifted_wide;
    logic [WORD_SIZE-1:0]     result;

    always_comb begin
        prod     = $signed(x_i) * $signed(w_i);
        prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        bias_ext = $signed({{(ACC_W - WORD_SIZE){bias_i[WORD_SIZE-1]}}, bias_i}) <<< FRAC;
        acc_sum  = acc_q + prod_ext;
        // The result is taken from the running sum so the final tap is included.
        shifted      = acc_sum >>> FRAC;
        shifted_wide = {{(64 - ACC_W){shifted[ACC_W-1]}}, shifted};
        result       = WORD_SIZE'(saturate(shifted_wide, WORD_SIZE));
`ifdef CONV_RELU_EN
        if (result[WORD_SIZE-1]) begin
            result = '0;
        end
`endif
    end

    always_comb begin
        acc_d  = acc_q;
        data_d = data_q;
        if (clear_i) begin
            acc_d = bias_ext;
        end else if (acc_en_i) begin
            acc_d = acc_sum;
            if (last_i) begin
                data_d = result;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_q  <= '0;
            data_q <= '0;
        end else begin
            acc_q  <= acc_d;
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/conv_layer_core.sv
// Single-channel 1-D convolution layer: loads a frame from a word FIFO, runs all
// output nodes in parallel and offers the result under valid/yumi. ReLU: CONV_RELU_EN.
module conv_layer_core
    import conv_pkg::*;
#(
    parameter int INPUT_LAYER_HEIGHT = 4,
    parameter int KERNEL_HEIGHT      = 3,
    parameter int KERNEL_WIDTH       = 2,
    parameter int WORD_SIZE          = 8,
    parameter int INT_BITS           = 8,
    parameter int LAYER_NUMBER       = 1,
    parameter int CONVOLUTION_NUMBER = 0,
    localparam int N_OUT             = INPUT_LAYER_HEIGHT - KERNEL_HEIGHT + 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       start_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [WORD_SIZE-1:0]       data_i,
    output logic                       valid_o,
    input  logic                       yumi_i,
    output logic [N_OUT*WORD_SIZE-1:0] data_o
);

    localparam int TOTAL  = INPUT_LAYER_HEIGHT * KERNEL_WIDTH;
    localparam int KTOT   = KERNEL_HEIGHT * KERNEL_WIDTH;
    localparam int IDX_W  = $clog2(TOTAL);
    localparam int KIDX_W = $clog2(KTOT);

    conv_state_e          state_q, state_d;
    logic [IDX_W-1:0]     word_cnt_q, word_cnt_d;
    logic [IDX_W-1:0]     comp_cnt_q, comp_cnt_d;
    logic [WORD_SIZE-1:0] x_mem_q [TOTAL];
    logic [WORD_SIZE-1:0] x_mem_d [TOTAL];
    logic [WORD_SIZE-1:0] w_rom   [KTOT];
    logic [WORD_SIZE-1:0] bias;
    logic                 accept;
    logic                 last_word;
    logic                 last_tap;
    logic                 node_clear;
    logic                 node_acc_en;
    logic [WORD_SIZE-1:0] w_cur;

    assign bias = WORD_SIZE'(kernel_bias(LAYER_NUMBER, CONVOLUTION_NUMBER));

    generate
        for (genvar gi = 0; gi < KTOT; gi++) begin : g_rom
            assign w_rom[gi] = WORD_SIZE'(kernel_weight(LAYER_NUMBER, CONVOLUTION_NUMBER, gi));
        end
    endgenerate

    assign ready_o     = (state_q == LOAD);
    assign valid_o     = (state_q == DONE);
    assign accept      = ready_o && valid_i;
    assign last_word   = (word_cnt_q == IDX_W'(TOTAL - 1));
    assign last_tap    = (comp_cnt_q == IDX_W'(KTOT - 1));
    assign node_clear  = (state_q != COMPUTE);
    assign node_acc_en = (state_q == COMPUTE);
    assign w_cur       = w_rom[comp_cnt_q[KIDX_W-1:0]];

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        comp_cnt_d = comp_cnt_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = LOAD;
                    word_cnt_d = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (last_word) begin
                        state_d    = COMPUTE;
                        word_cnt_d = '0;
                        comp_cnt_d = '0;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            COMPUTE: begin
                if (last_tap) begin
                    state_d    = DONE;
                    comp_cnt_d = '0;
                end else begin
                    comp_cnt_d = comp_cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (yumi_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        x_mem_d = x_mem_q;
        if (accept) begin
            x_mem_d[word_cnt_q] = data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            comp_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            comp_cnt_q <= comp_cnt_d;
        end
    end

    // Frame storage needs no reset: every frame overwrites all words before use.
    always_ff @(posedge clk_i) begin
        x_mem_q <= x_mem_d;
    end

    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_node
            logic [IDX_W-1:0] x_idx;
            // Node n at tap k reads x[n+r][c], which is frame word n*KW+k.
            assign x_idx = IDX_W'(gi * KERNEL_WIDTH) + comp_cnt_q;

            conv_mac_node #(
                .WORD_SIZE    (WORD_SIZE),
                .INT_BITS     (INT_BITS),
                .KERNEL_HEIGHT(KERNEL_HEIGHT),
                .KERNEL_WIDTH (KERNEL_WIDTH)
            ) u_node (
                .clk_i   (clk_i),
                .reset_i (reset_i),
                .clear_i (node_clear),
                .acc_en_i(node_acc_en),
                .last_i  (last_tap),
                .x_i     (x_mem_q[x_idx]),
                .w_i     (w_cur),
                .bias_i  (bias),
                .data_o  (data_o[gi*WORD_SIZE +: WORD_SIZE])
            );
        end
    endgenerate

endmodule

// File: tb/tb_conv_layer_core.sv
// Directed bench for conv_layer_core with the default 4x2 frame, 3x2 kernel, bias 0x0f.
module tb_conv_layer_core;

    typedef logic [7:0] frame_t [8];

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        start_i;
    logic        valid_i;
    logic        ready_o;
    logic [7:0]  data_i;
    logic        valid_o;
    logic        yumi_i;
    logic [15:0] data_o;

    int tests_run    = 0;
    int tests_failed = 0;

`ifdef CONV_RELU_EN
    localparam logic [15:0] EXP_NEG = 16'h0000;
`else
    localparam logic [15:0] EXP_NEG = 16'hfdfd;
`endif

    always #5 clk_i = ~clk_i;

    conv_layer_core dut (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .start_i(start_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .data_i (data_i),
        .valid_o(valid_o),
        .yumi_i (yumi_i),
        .data_o (data_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts a frame, feeds it (optionally with FIFO-empty gaps), then waits for valid_o.
    task automatic run_frame(input frame_t f, input bit gaps, input logic [15:0] exp,
                             input string tag);
        int lat;
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        check({tag, "_ready_in_load"}, 32'(ready_o), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (gaps && (i % 2 == 1)) begin
                valid_i = 1'b0;
                data_i  = 8'haa;
                @(negedge clk_i);
            end
            valid_i = 1'b1;
            data_i  = f[i];
            @(negedge clk_i);
        end
        valid_i = 1'b0;
        data_i  = 8'h00;
        lat = 1;
        while (!valid_o && lat < 50) begin
            @(negedge clk_i);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd7);
        check({tag, "_data"}, 32'(data_o), 32'(exp));
    endtask

    // Consumes the result with start_i held high in the same cycle.
    task automatic consume(input string tag);
        yumi_i  = 1'b1;
        start_i = 1'b1;
        @(negedge clk_i);
        yumi_i  = 1'b0;
        start_i = 1'b0;
        check({tag, "_valid_after_yumi"}, 32'(valid_o), 32'd0);
        check({tag, "_ready_after_yumi"}, 32'(ready_o), 32'd0);
        repeat (3) @(negedge clk_i);
        check({tag, "_ready_idle"}, 32'(ready_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        frame_t f1;
        frame_t f2;
        frame_t f3;
        f1 = '{8'h01, 8'h05, 8'h03, 8'h02, 8'h09, 8'h05, 8'h00, 8'h01};
        f2 = '{8'h03, 8'h01, 8'h01, 8'h02, 8'h0f, 8'h0f, 8'h08, 8'h06};
        f3 = '{8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff};

        reset_i = 1'b1;
        start_i = 1'b0;
        valid_i = 1'b0;
        data_i  = 8'h00;
        yumi_i  = 1'b0;
        repeat (3) @(negedge clk_i);
        check("reset_valid", 32'(valid_o), 32'd0);
        check("reset_ready", 32'(ready_o), 32'd0);
        check("reset_data", 32'(data_o), 32'd0);
        reset_i = 1'b0;

        // valid_i high while idle must not be consumed
        valid_i = 1'b1;
        @(negedge clk_i);
        check("idle_ready", 32'(ready_o), 32'd0);
        valid_i = 1'b0;

        run_frame(f1, 1'b0, 16'h435c, "frame1");
        // hold yumi low: output must stay put
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            check("hold_valid", 32'(valid_o), 32'd1);
            check("hold_data", 32'(data_o), 32'h435c);
        end
        consume("frame1");

        run_frame(f2, 1'b0, 16'h7f6e, "frame2_sat");
        consume("frame2");

        run_frame(f3, 1'b0, EXP_NEG, "frame3_neg");
        consume("frame3");

        run_frame(f1, 1'b1, 16'h435c, "frame1_gaps");
        consume("frame1_gaps");

        // abort after 3 words
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1;
            data_i  = f2[i];
            @(negedge clk_i);
        end
        valid_i = 1'b0;
        reset_i = 1'b1;
        @(negedge clk_i);
        check("abort_ready", 32'(ready_o), 32'd0);
        check("abort_valid", 32'(valid_o), 32'd0);
        check("abort_data", 32'(data_o), 32'd0);
        reset_i = 1'b0;

        run_frame(f1, 1'b0, 16'h435c, "frame_after_abort");
        consume("frame_after_abort");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
